// File: rtl/gate_seq_ctrl.sv
// Truth-table sequencer: walks a 4-input gate block through all 16 input
// vectors in reflected Gray order and captures its three outputs per vector.
module gate_seq_ctrl #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        e_in,
  input  logic        f_in,
  input  logic        g_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        cap_valid,
  output logic [3:0]  vec_idx,
  output logic [15:0] res_e,
  output logic [15:0] res_f,
  output logic [15:0] res_g
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_idx_q, vec_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  stim_q, stim_d;
  logic [15:0] res_e_q, res_e_d;
  logic [15:0] res_f_q, res_f_d;
  logic [15:0] res_g_q, res_g_d;

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    cnt_d     = cnt_q;
    res_e_d   = res_e_q;
    res_f_d   = res_f_q;
    res_g_d   = res_g_q;

    case (state_q)
      IDLE: begin
        vec_idx_d = 4'd0;
        if (start) begin
          state_d = DRIVE;
          cnt_d   = DWELL_M1;
          res_e_d = 16'h0000;
          res_f_d = 16'h0000;
          res_g_d = 16'h0000;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d   = IDLE;
          vec_idx_d = 4'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        // The capture lands even when this cycle is aborted.
        res_e_d[stim_q] = e_in;
        res_f_d[stim_q] = f_in;
        res_g_d[stim_q] = g_in;
        if (abort) begin
          state_d   = IDLE;
          vec_idx_d = 4'd0;
        end else if (vec_idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d   = DRIVE;
          vec_idx_d = vec_idx_q + 4'd1;
          cnt_d     = DWELL_M1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        vec_idx_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        vec_idx_d = 4'd0;
      end
    endcase

    // Stimulus is precomputed for the next state so a..d come straight from flops.
    if (state_d == DRIVE || state_d == SAMPLE) begin
      stim_d = vec_idx_d ^ (vec_idx_d >> 1);
    end else begin
      stim_d = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vec_idx_q <= 4'd0;
      cnt_q     <= 8'd0;
      stim_q    <= 4'b0000;
      res_e_q   <= 16'h0000;
      res_f_q   <= 16'h0000;
      res_g_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      cnt_q     <= cnt_d;
      stim_q    <= stim_d;
      res_e_q   <= res_e_d;
      res_f_q   <= res_f_d;
      res_g_q   <= res_g_d;
    end
  end

  assign a         = stim_q[0];
  assign b         = stim_q[1];
  assign c         = stim_q[2];
  assign d         = stim_q[3];
  assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign cap_valid = (state_q == SAMPLE);
  assign vec_idx   = vec_idx_q;
  assign res_e     = res_e_q;
  assign res_f     = res_f_q;
  assign res_g     = res_g_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: three instances (DWELL 4, 1, 255) each driving a
// truth-table gate model; runs are scored against the expected tables and timing.
module tb_gate_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [2:0]        start, abort, e_in, f_in, g_in;
  logic [2:0]        a, b, c, d, busy, done, cap_valid;
  logic [2:0][3:0]   vec_idx;
  logic [2:0][15:0]  res_e, res_f, res_g;
  logic [15:0]       tt_e, tt_f, tt_g;

  int total = 0;
  int bad   = 0;

  // Expected application order, written out literally.
  logic [3:0] seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  function automatic int dw_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 255;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      gate_seq_ctrl #(.DWELL(dw_of(gi))) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start[gi]), .abort(abort[gi]),
        .e_in(e_in[gi]), .f_in(f_in[gi]), .g_in(g_in[gi]),
        .a(a[gi]), .b(b[gi]), .c(c[gi]), .d(d[gi]),
        .busy(busy[gi]), .done(done[gi]), .cap_valid(cap_valid[gi]),
        .vec_idx(vec_idx[gi]), .res_e(res_e[gi]), .res_f(res_f[gi]), .res_g(res_g[gi])
      );
      assign e_in[gi] = tt_e[{d[gi], c[gi], b[gi], a[gi]}];
      assign f_in[gi] = tt_f[{d[gi], c[gi], b[gi], a[gi]}];
      assign g_in[gi] = tt_g[{d[gi], c[gi], b[gi], a[gi]}];
    end
  endgenerate

  function automatic logic [3:0] stim(input int k);
    return {d[k], c[k], b[k], a[k]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_spec_model;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      tt_e[i] = v[0] & v[1] & v[2];
      tt_f[i] = v[1] & v[2] & v[3];
      tt_g[i] = v[0] & v[1] & v[2] & v[3];
    end
  endtask

  task automatic set_random_model;
    tt_e = 16'($urandom);
    tt_f = 16'($urandom);
    tt_g = 16'($urandom);
  endtask

  // Run recording (observations only; scenarios judge them).
  int         done_cyc, ncap, gray_bad;
  int         cap_cyc [16];
  logic [3:0] cap_idx [16];
  logic [3:0] cap_stim [16];
  logic       done_busy;
  logic [3:0] done_stim, done_idx;
  logic [15:0] res_first;

  task automatic run_collect(input int k, input bit jitter, input bit hold);
    int cyc;
    logic [3:0] prev;
    start[k] = 1'b1;
    tick();
    start[k] = hold;
    cyc = 1; ncap = 0; gray_bad = 0; done_cyc = -1;
    prev = stim(k);
    res_first = res_e[k] | res_f[k] | res_g[k];
    while (done_cyc < 0 && cyc <= 16 * (dw_of(k) + 1) + 10) begin
      if (cap_valid[k]) begin
        if (ncap < 16) begin
          cap_cyc[ncap] = cyc; cap_idx[ncap] = vec_idx[k]; cap_stim[ncap] = stim(k);
        end
        ncap++;
      end
      if (busy[k] && stim(k) != prev) begin
        if ($countones(stim(k) ^ prev) != 1) gray_bad++;
        prev = stim(k);
      end
      if (done[k]) begin
        done_cyc = cyc; done_busy = busy[k]; done_stim = stim(k); done_idx = vec_idx[k];
      end else begin
        if (jitter && !hold) start[k] = (busy[k] && vec_idx[k] != 4'd15) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        cyc++;
      end
    end
    if (!hold) start[k] = 1'b0;
    $display("run k=%0d dwell=%0d done_cyc=%0d caps=%0d res_e=%h res_f=%h res_g=%h",
             k, dw_of(k), done_cyc, ncap, res_e[k], res_f[k], res_g[k]);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = '0; abort = '0;
    set_spec_model();
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({busy[k], done[k], cap_valid[k], vec_idx[k], stim(k)} !== 11'd0) begin
        bad++; $display("FAIL reset_ctrl k=%0d: got %h want 0", k, {busy[k], done[k], cap_valid[k], vec_idx[k], stim(k)});
      end
      total++;
      if ({res_e[k], res_f[k], res_g[k]} !== 48'd0) begin
        bad++; $display("FAIL reset_res k=%0d: got %h want 0", k, {res_e[k], res_f[k], res_g[k]});
      end
    end
  endtask

  task automatic test_spec_model;
    set_spec_model();
    run_collect(0, 1'b0, 1'b0);
    total++;
    if (done_cyc != 81) begin bad++; $display("FAIL spec_latency: got %0d want 81", done_cyc); end
    total++;
    if (ncap != 16) begin bad++; $display("FAIL spec_caps: got %0d want 16", ncap); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cap_stim[i] !== seq[i] || cap_idx[i] !== 4'(i) || cap_cyc[i] != (i + 1) * 5) begin
        bad++; $display("FAIL spec_cap%0d: got stim=%0d idx=%0d cyc=%0d want stim=%0d idx=%0d cyc=%0d",
                        i, cap_stim[i], cap_idx[i], cap_cyc[i], seq[i], i, (i + 1) * 5);
      end
    end
    total++;
    if (gray_bad != 0) begin bad++; $display("FAIL spec_gray: got %0d multi-bit steps want 0", gray_bad); end
    total++;
    if ({done_busy, done_stim, done_idx} !== {1'b0, 4'd0, 4'd15}) begin
      bad++; $display("FAIL spec_done_state: got %h want %h", {done_busy, done_stim, done_idx}, {1'b0, 4'd0, 4'd15});
    end
    total++;
    if ({res_e[0], res_f[0], res_g[0]} !== {16'h8080, 16'hC000, 16'h8000}) begin
      bad++; $display("FAIL spec_res: got %h %h %h want 8080 c000 8000", res_e[0], res_f[0], res_g[0]);
    end
    tick();
    total++;
    if ({done[0], busy[0], vec_idx[0]} !== 6'd0) begin
      bad++; $display("FAIL spec_idle_after: got %h want 0", {done[0], busy[0], vec_idx[0]});
    end
  endtask

  task automatic test_random_runs;
    for (int r = 0; r < 3; r++) begin
      logic [15:0] held;
      set_random_model();
      run_collect(0, 1'b1, 1'b0);
      total++;
      if (res_first !== 16'h0000) begin bad++; $display("FAIL rnd%0d_clear: got %h want 0", r, res_first); end
      total++;
      if (done_cyc != 81 || ncap != 16 || gray_bad != 0) begin
        bad++; $display("FAIL rnd%0d_timing: got lat=%0d caps=%0d gray=%0d want 81 16 0", r, done_cyc, ncap, gray_bad);
      end
      total++;
      if ({res_e[0], res_f[0], res_g[0]} !== {tt_e, tt_f, tt_g}) begin
        bad++; $display("FAIL rnd%0d_res: got %h %h %h want %h %h %h", r, res_e[0], res_f[0], res_g[0], tt_e, tt_f, tt_g);
      end
      held = res_e[0];
      tt_e = ~tt_e;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (res_e[0] !== held || done[0] !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_hold: got %h done=%0d want %h done=0", r, res_e[0], done[0], held);
      end
    end
  endtask

  task automatic test_dwell_edges;
    for (int k = 1; k < 3; k++) begin
      int spacing_bad;
      set_random_model();
      run_collect(k, 1'b0, 1'b0);
      spacing_bad = 0;
      for (int i = 0; i < 16; i++) if (cap_cyc[i] != (i + 1) * (dw_of(k) + 1)) spacing_bad++;
      total++;
      if (done_cyc != 16 * (dw_of(k) + 1) + 1) begin
        bad++; $display("FAIL dwell%0d_latency: got %0d want %0d", dw_of(k), done_cyc, 16 * (dw_of(k) + 1) + 1);
      end
      total++;
      if (ncap != 16 || spacing_bad != 0) begin
        bad++; $display("FAIL dwell%0d_caps: got caps=%0d misplaced=%0d want 16 0", dw_of(k), ncap, spacing_bad);
      end
      total++;
      if ({res_e[k], res_f[k], res_g[k]} !== {tt_e, tt_f, tt_g}) begin
        bad++; $display("FAIL dwell%0d_res: got %h %h %h want %h %h %h", dw_of(k), res_e[k], res_f[k], res_g[k], tt_e, tt_f, tt_g);
      end
      tick();
    end
  endtask

  task automatic test_hold_start;
    set_random_model();
    run_collect(0, 1'b0, 1'b1);
    total++;
    if (done_cyc != 81 || ncap != 16 || done_busy !== 1'b0) begin
      bad++; $display("FAIL hold_run: got lat=%0d caps=%0d busy=%0d want 81 16 0", done_cyc, ncap, done_busy);
    end
    tick();
    total++;
    if ({busy[0], done[0], vec_idx[0]} !== 6'd0) begin
      bad++; $display("FAIL hold_idle: got %h want 0", {busy[0], done[0], vec_idx[0]});
    end
    tick();
    total++;
    if (busy[0] !== 1'b1) begin bad++; $display("FAIL hold_restart: got busy=%0d want 1", busy[0]); end
    start[0] = 1'b0; abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL hold_abort: got busy=%0d want 0", busy[0]); end
  endtask

  task automatic test_abort_drive;
    int n;
    logic [15:0] mask;
    set_random_model();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!(busy[0] && !cap_valid[0] && vec_idx[0] == 4'd5) && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL abort5_reach: got timeout want vec_idx=5"); end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    mask = 16'h0000;
    for (int i = 0; i < 5; i++) mask[seq[i]] = 1'b1;
    total++;
    if ({busy[0], done[0], cap_valid[0], vec_idx[0], stim(0)} !== 11'd0) begin
      bad++; $display("FAIL abort5_state: got %h want 0", {busy[0], done[0], cap_valid[0], vec_idx[0], stim(0)});
    end
    total++;
    if ({res_e[0], res_f[0], res_g[0]} !== {tt_e & mask, tt_f & mask, tt_g & mask}) begin
      bad++; $display("FAIL abort5_res: got %h %h %h want %h %h %h", res_e[0], res_f[0], res_g[0], tt_e & mask, tt_f & mask, tt_g & mask);
    end
    abort[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || res_e[0] !== (tt_e & mask)) begin
      bad++; $display("FAIL abort_idle: got busy=%0d done=%0d res_e=%h want 0 0 %h", busy[0], done[0], res_e[0], tt_e & mask);
    end
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b1 || res_e[0] !== 16'h0000) begin
      bad++; $display("FAIL start_beats_abort: got busy=%0d res_e=%h want 1 0000", busy[0], res_e[0]);
    end
    tick(); abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL abort_after_start: got busy=%0d want 0", busy[0]); end
  endtask

  task automatic test_abort_final;
    int n;
    set_random_model();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!(cap_valid[0] && vec_idx[0] == 4'd15) && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL final_reach: got timeout want last sample"); end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL final_abort_state: got done=%0d busy=%0d want 0 0", done[0], busy[0]);
    end
    total++;
    if ({res_e[0], res_f[0], res_g[0]} !== {tt_e, tt_f, tt_g}) begin
      bad++; $display("FAIL final_abort_res: got %h %h %h want %h %h %h", res_e[0], res_f[0], res_g[0], tt_e, tt_f, tt_g);
    end
    tick();
    total++;
    if (done[0] !== 1'b0) begin bad++; $display("FAIL final_no_done: got %0d want 0", done[0]); end
  endtask

  task automatic test_reset_mid;
    int n;
    set_random_model();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (vec_idx[0] != 4'd9 && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL rstmid_reach: got timeout want vec_idx=9"); end
    reset_n = 1'b0; start[0] = 1'b1; abort[0] = 1'b1;
    tick();
    reset_n = 1'b1; start[0] = 1'b0; abort[0] = 1'b0;
    total++;
    if ({busy[0], done[0], cap_valid[0], vec_idx[0], stim(0), res_e[0], res_f[0], res_g[0]} !== 59'd0) begin
      bad++; $display("FAIL rstmid_state: got busy=%0d done=%0d cap=%0d idx=%0d stim=%0d res=%h%h%h want all 0",
                      busy[0], done[0], cap_valid[0], vec_idx[0], stim(0), res_e[0], res_f[0], res_g[0]);
    end
    tick(); tick();
    total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet: got done=%0d busy=%0d want 0 0", done[0], busy[0]);
    end
    set_spec_model();
    run_collect(0, 1'b0, 1'b0);
    total++;
    if (done_cyc != 81 || {res_e[0], res_f[0], res_g[0]} !== {16'h8080, 16'hC000, 16'h8000}) begin
      bad++; $display("FAIL rstmid_rerun: got lat=%0d res=%h %h %h want 81 8080 c000 8000", done_cyc, res_e[0], res_f[0], res_g[0]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_model();
    test_random_runs();
    test_dwell_edges();
    test_hold_start();
    test_abort_drive();
    test_abort_final();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, settle cycles per vector before sampling; legal range 1..255.
REQ-002 Clocking: the block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  level-sampled run request; honoured only in IDLE.
REQ-006 abort  input  1  synchronous abort of a run in progress.
REQ-007 e_in, f_in, g_in  input  1 each  outputs returned from the gate block under sequence.
REQ-008 a, b, c, d  output  1 each  stimulus driven to the gate block's inputs.
REQ-009 busy  output  1  high in DRIVE and SAMPLE.
REQ-010 done  output  1  one-cycle pulse on run completion.
REQ-011 cap_valid  output  1  one-cycle pulse per captured vector.
REQ-012 vec_idx  output  4  sequence step count (0..15) of the vector currently applied.
REQ-013 res_e, res_f, res_g  output  16 each  captured truth tables, bit n = response to vector n = {d,c,b,a}.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE, with IDLE the only state entered from reset.
REQ-015 IDLE: a..d=0, busy=0, vec_idx=0; start=1 -> DRIVE next cycle; res_* cleared to 0 on that same edge.
REQ-016 Vector order SHALL be reflected Gray: {d,c,b,a} = vec_idx ^ (vec_idx >> 1), so exactly one stimulus bit changes per step.
REQ-017 DRIVE: hold the vector for exactly DWELL cycles (down-counter loaded with DWELL-1 on entry), then -> SAMPLE.
REQ-018 SAMPLE (one cycle): write e_in/f_in/g_in into bit {d,c,b,a} of res_e/res_f/res_g; cap_valid=1 this cycle; stimulus unchanged.
REQ-019 SAMPLE exit: vec_idx<15 -> vec_idx+1, DRIVE; vec_idx==15 -> DONE, vec_idx unchanged.
REQ-020 DONE (one cycle): done=1, busy=0, a..d=0, then -> IDLE; res_* SHALL hold until the next accepted start.
REQ-021 Latency: done SHALL assert exactly 16*(DWELL+1)+1 cycles after the edge that samples start in IDLE (81 for DWELL=4).
REQ-022 start while busy or in DONE SHALL be ignored, with no restart or queuing.
REQ-023 abort=1 in DRIVE or SAMPLE -> IDLE next cycle; no done, no cap_valid, a..d=0; res_* keep partial contents; abort in IDLE/DONE has no effect.
REQ-024 abort and start both high in IDLE: start wins and the run begins.
REQ-025 abort coincident with the final SAMPLE: abort wins; the capture from that cycle is still written, but done is not pulsed.
REQ-026 Stimulus outputs SHALL be registered, with no combinational path from start/abort to a..d.

Reset
REQ-027 reset_n=0 at a rising edge -> next cycle: state IDLE; a..d=0, busy=0, done=0, cap_valid=0, vec_idx=0, res_*=16'h0000, dwell counter=0.
REQ-028 Reset mid-run SHALL take precedence over start, abort and every FSM transition, with no done pulse.

Verification
REQ-029 Bench model: e=a&b&c, f=b&c&d, g=a&b&c&d, DWELL=4, one start pulse -> done at cycle 81; res_e=16'h8080, res_f=16'hC000, res_g=16'h8000; 16 cap_valid pulses.
REQ-030 Gray check: on every vector change during a run, exactly one of a..d toggles, and the sequence of {d,c,b,a} is 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
REQ-031 DWELL=1: done at cycle 33 and cap_valid every 2nd cycle; DWELL=255: done at cycle 4097.
REQ-032 start held high throughout the run -> one run only; busy=0 in the DONE cycle, and a new run starts from the IDLE cycle after it.
REQ-033 abort during DRIVE at vec_idx=5 -> IDLE next cycle with a..d=0 and no done; res_e keeps 5 written bits, with bits for vectors {0,1,3,2,6} valid.
REQ-034 reset_n=0 for one cycle at vec_idx=9 -> all outputs at reset values next cycle; start afterwards completes a normal run with the REQ-029 results.
